// File: rtl/ftm_ts_capture_pkg.sv
// Shared FTM timestamp types: entry layout, RX verdict FSM states and default widths.
package ftm_ts_capture_pkg;

   localparam int TS_W  = 48;
   localparam int SEQ_W = 12;

   typedef struct packed {
      logic [TS_W-1:0]  ts_time;
      logic             dir;
      logic [SEQ_W-1:0] seq;
      logic             wrap;
   } ts_entry_t;

   typedef enum logic [1:0] {
      RX_IDLE = 2'd0,
      RX_PEND = 2'd1,
      RX_HOLD = 2'd2
   } rx_state_t;

endpackage

// File: rtl/ftm_ts_capture_if.sv
// Timestamp pop port: valid/ready handshake plus head-entry fields.
interface ftm_ts_capture_if #(
   parameter int TS_W  = ftm_ts_capture_pkg::TS_W,
   parameter int SEQ_W = ftm_ts_capture_pkg::SEQ_W
);
   logic             ts_valid;
   logic             ts_ready;
   logic [TS_W-1:0]  ts_time;
   logic             ts_dir;
   logic [SEQ_W-1:0] ts_seq;
   logic             ts_wrap;

   modport master (output ts_valid, ts_time, ts_dir, ts_seq, ts_wrap, input ts_ready);
   modport slave  (input ts_valid, ts_time, ts_dir, ts_seq, ts_wrap, output ts_ready);
endinterface

// File: rtl/ftm_ts_fifo.sv
// Single-clock first-word-fall-through FIFO; a write is visible at the head the cycle after it.
// Writes into a full FIFO are dropped unless a pop happens in the same cycle.
module ftm_ts_fifo #(
   parameter int DEPTH = 8,
   parameter int W     = 62
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   wr_en_i,
   input  logic [W-1:0]           wr_dat_i,
   input  logic                   rd_en_i,
   output logic [W-1:0]           rd_dat_o,
   output logic                   vld_o,
   output logic                   acc_o,
   output logic                   drop_o,
   output logic [$clog2(DEPTH):0] level_o
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0] mem_q [DEPTH];
   logic [AW:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [W-1:0] last_q, last_d;
   logic         empty, full, pop;

   assign empty  = (wr_ptr_q == rd_ptr_q);
   assign full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign pop    = rd_en_i & ~empty;
   assign acc_o  = wr_en_i & (~full | pop);
   assign drop_o = wr_en_i & ~acc_o;

   // When empty the head shows the last popped entry rather than stale memory.
   assign rd_dat_o = empty ? last_q : mem_q[rd_ptr_q[AW-1:0]];
   assign vld_o    = ~empty;
   assign level_o  = wr_ptr_q - rd_ptr_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, acc_o};
      rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
      last_d   = pop ? mem_q[rd_ptr_q[AW-1:0]] : last_q;
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         last_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         last_q   <= last_d;
      end
   end

   always_ff @(posedge clk) begin
      if (acc_o) mem_q[wr_ptr_q[AW-1:0]] <= wr_dat_i;
   end

endmodule

// File: rtl/ftm_ts_capture.sv
// Captures TX/RX frame timestamps into a FIFO; TX entries appear at the head one cycle after tx_ev.
// RX entries wait for the FCS verdict; the pop side uses valid/ready, overflow is dropped and counted.
module ftm_ts_capture #(
   parameter int DEPTH = 8,
   parameter int TS_W  = ftm_ts_capture_pkg::TS_W
) (
   input  logic                                 clk,
   input  logic                                 rstn,
   input  logic [TS_W-1:0]                      ftm_time_i,
   input  logic                                 tx_ev_i,
   input  logic                                 rx_ev_i,
   input  logic                                 rx_fcs_ok_i,
   input  logic                                 rx_fcs_bad_i,
   input  logic [ftm_ts_capture_pkg::SEQ_W-1:0] ev_seq_i,
   ftm_ts_capture_if.master                     pop_if,
   output logic [$clog2(DEPTH):0]               level_o,
   output logic [15:0]                          drop_cnt_o
);
   import ftm_ts_capture_pkg::*;

   typedef struct packed {
      logic [TS_W-1:0]  ts_time;
      logic             dir;
      logic [SEQ_W-1:0] seq;
      logic             wrap;
   } cap_entry_t;

   rx_state_t        state_q, state_d;
   logic [TS_W-1:0]  pend_time_q, hold_time_q, prev_q;
   logic [SEQ_W-1:0] pend_seq_q, hold_seq_q;
   logic             capt_q, capt_d;
   logic             wrap_pend_q, wrap_pend_d, wrap_now;
   logic [15:0]      drop_q, drop_d;
   logic [1:0]       drop_inc;
   logic             fcs_ok, fcs_bad;
   logic             rx_wr, rx_from_hold, hold_load, ovr_drop;
   logic             wr_en, fifo_acc, fifo_drop, fifo_vld;
   cap_entry_t       wr_dat, head;

   assign fcs_bad = rx_fcs_bad_i;
   assign fcs_ok  = rx_fcs_ok_i & ~rx_fcs_bad_i;

   always_ff @(posedge clk) begin
      if (!rstn) state_q <= RX_IDLE;
      else       state_q <= state_d;
   end

   // TX owns the single write port, so a held RX entry retries until a cycle without tx_ev.
   always_comb begin
      state_d = state_q;
      case (state_q)
         RX_IDLE: if (rx_ev_i) state_d = RX_PEND;
         RX_PEND: begin
            if (fcs_ok && tx_ev_i)          state_d = RX_HOLD;
            else if ((fcs_ok || fcs_bad) && !rx_ev_i) state_d = RX_IDLE;
         end
         RX_HOLD: if (!tx_ev_i) state_d = (capt_q || rx_ev_i) ? RX_PEND : RX_IDLE;
         default: state_d = RX_IDLE;
      endcase
   end

   always_comb begin
      rx_wr        = 1'b0;
      rx_from_hold = 1'b0;
      hold_load    = 1'b0;
      ovr_drop     = 1'b0;
      capt_d       = 1'b0;
      case (state_q)
         RX_PEND: begin
            rx_wr     = fcs_ok & ~tx_ev_i;
            hold_load = fcs_ok & tx_ev_i;
            ovr_drop  = rx_ev_i & ~fcs_ok & ~fcs_bad;
            capt_d    = fcs_ok & tx_ev_i & rx_ev_i;
         end
         RX_HOLD: begin
            rx_wr        = ~tx_ev_i;
            rx_from_hold = 1'b1;
            ovr_drop     = rx_ev_i & capt_q;
            capt_d       = tx_ev_i & (capt_q | rx_ev_i);
         end
         default: ;
      endcase
   end

   assign wrap_now    = (ftm_time_i < prev_q);
   assign wrap_pend_d = (wrap_pend_q | wrap_now) & ~fifo_acc;

   assign wr_en = tx_ev_i | rx_wr;

   always_comb begin
      wr_dat      = '0;
      wr_dat.wrap = wrap_pend_q | wrap_now;
      if (tx_ev_i) begin
         wr_dat.ts_time = ftm_time_i;
         wr_dat.dir     = 1'b1;
         wr_dat.seq     = ev_seq_i;
      end else if (rx_from_hold) begin
         wr_dat.ts_time = hold_time_q;
         wr_dat.seq     = hold_seq_q;
      end else begin
         wr_dat.ts_time = pend_time_q;
         wr_dat.seq     = pend_seq_q;
      end
   end

   assign drop_inc = {1'b0, ovr_drop} + {1'b0, fifo_drop};
   assign drop_d   = (drop_q > (16'hFFFF - {14'd0, drop_inc})) ? 16'hFFFF : drop_q + {14'd0, drop_inc};

   always_ff @(posedge clk) begin
      if (!rstn) begin
         prev_q      <= '0;
         wrap_pend_q <= 1'b0;
         drop_q      <= '0;
         capt_q      <= 1'b0;
         pend_time_q <= '0;
         pend_seq_q  <= '0;
         hold_time_q <= '0;
         hold_seq_q  <= '0;
      end else begin
         prev_q      <= ftm_time_i;
         wrap_pend_q <= wrap_pend_d;
         drop_q      <= drop_d;
         capt_q      <= capt_d;
         if (rx_ev_i) begin
            pend_time_q <= ftm_time_i;
            pend_seq_q  <= ev_seq_i;
         end
         if (hold_load) begin
            hold_time_q <= pend_time_q;
            hold_seq_q  <= pend_seq_q;
         end
      end
   end

   ftm_ts_fifo #(.DEPTH(DEPTH), .W($bits(cap_entry_t))) u_fifo (
      .clk      (clk),
      .rstn     (rstn),
      .wr_en_i  (wr_en),
      .wr_dat_i (wr_dat),
      .rd_en_i  (pop_if.ts_ready & fifo_vld),
      .rd_dat_o (head),
      .vld_o    (fifo_vld),
      .acc_o    (fifo_acc),
      .drop_o   (fifo_drop),
      .level_o  (level_o)
   );

   assign pop_if.ts_valid = fifo_vld;
   assign pop_if.ts_time  = head.ts_time;
   assign pop_if.ts_dir   = head.dir;
   assign pop_if.ts_seq   = head.seq;
   assign pop_if.ts_wrap  = head.wrap;
   assign drop_cnt_o      = drop_q;

endmodule

// File: tb/tb_ftm_ts_capture.sv
// Bench for ftm_ts_capture: directed scenarios plus randomized traffic against a queue-based model.
module tb_ftm_ts_capture;
   import ftm_ts_capture_pkg::*;

   localparam int DEPTH = 8;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic [47:0] ftm_time = '0;
   logic        tx_ev = 1'b0, rx_ev = 1'b0, ok = 1'b0, bad = 1'b0, ready = 1'b0;
   logic [11:0] seq = '0;
   logic [3:0]  level;
   logic [15:0] drop_cnt;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   ftm_ts_capture_if pop_if ();
   assign pop_if.ts_ready = ready;

   ftm_ts_capture #(.DEPTH(DEPTH), .TS_W(TS_W)) dut (
      .clk          (clk),
      .rstn         (rstn),
      .ftm_time_i   (ftm_time),
      .tx_ev_i      (tx_ev),
      .rx_ev_i      (rx_ev),
      .rx_fcs_ok_i  (ok),
      .rx_fcs_bad_i (bad),
      .ev_seq_i     (seq),
      .pop_if       (pop_if),
      .level_o      (level),
      .drop_cnt_o   (drop_cnt)
   );

   // Reference model: queue of committed entries, optional pending and held RX frames.
   ts_entry_t   mq[$];
   ts_entry_t   m_last, m_pend, m_held;
   bit          m_has_pend, m_has_held, m_wp;
   logic [47:0] m_prev;
   int          m_drops;

   task automatic model_step();
      bit w, have_push, pop;
      ts_entry_t e;
      if (!rstn) begin
         mq.delete();
         m_last = '0; m_drops = 0; m_wp = 0; m_prev = '0;
         m_has_pend = 0; m_has_held = 0;
      end else begin
         w = m_wp || (ftm_time < m_prev);
         have_push = 0;
         e = '0;
         if (tx_ev) begin
            have_push = 1;
            e = '{ftm_time, 1'b1, seq, 1'b0};
         end
         if (m_has_held) begin
            if (!tx_ev) begin
               have_push = 1; e = m_held; m_has_held = 0;
            end
         end else if (m_has_pend && (ok || bad)) begin
            m_has_pend = 0;
            if (!bad) begin
               if (tx_ev) begin m_held = m_pend; m_has_held = 1; end
               else begin have_push = 1; e = m_pend; end
            end
         end
         if (rx_ev) begin
            if (m_has_pend) m_drops++;
            m_pend = '{ftm_time, 1'b0, seq, 1'b0};
            m_has_pend = 1;
         end
         pop = ready && (mq.size() > 0);
         if (pop) m_last = mq.pop_front();
         if (have_push) begin
            if (mq.size() >= DEPTH) m_drops++;
            else begin
               e.wrap = w;
               mq.push_back(e);
               w = 0;
            end
         end
         m_prev = ftm_time;
         m_wp = w;
      end
   endtask

   task automatic cycle();
      model_step();
      @(posedge clk);
      #1;
      tx_ev = 0; rx_ev = 0; ok = 0; bad = 0;
   endtask

   task automatic do_reset();
      rstn = 0; ready = 0;
      cycle(); cycle();
      rstn = 1;
   endtask

   function automatic ts_entry_t head();
      ts_entry_t e;
      e.ts_time = pop_if.ts_time;
      e.dir     = pop_if.ts_dir;
      e.seq     = pop_if.ts_seq;
      e.wrap    = pop_if.ts_wrap;
      return e;
   endfunction

   task automatic test_reset();
      ts_entry_t act;
      rstn = 0; ftm_time = 48'd123; tx_ev = 1; seq = 12'd9;
      cycle(); cycle();
      act = head();
      checks++; if (pop_if.ts_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", pop_if.ts_valid); end
      checks++; if (act !== '0) begin failures++; $display("FAIL reset_head: got %h want 0", act); end
      checks++; if (level !== 4'd0) begin failures++; $display("FAIL reset_level: got %0d want 0", level); end
      checks++; if (drop_cnt !== 16'd0) begin failures++; $display("FAIL reset_drop: got %0d want 0", drop_cnt); end
      rstn = 1;
   endtask

   task automatic test_single_tx();
      ts_entry_t act, exp;
      do_reset();
      ftm_time = 48'd1000; seq = 12'd5; tx_ev = 1;
      cycle();
      exp = '{48'd1000, 1'b1, 12'd5, 1'b0};
      act = head();
      checks++; if (pop_if.ts_valid !== 1'b1) begin failures++; $display("FAIL tx_valid: got %b want 1", pop_if.ts_valid); end
      checks++; if (act !== exp) begin failures++; $display("FAIL tx_head: got %h want %h", act, exp); end
      checks++; if (level !== 4'd1) begin failures++; $display("FAIL tx_level: got %0d want 1", level); end
      ready = 1; ftm_time = 48'd1010;
      cycle(); cycle();
      ready = 0;
      act = head();
      checks++; if (pop_if.ts_valid !== 1'b0) begin failures++; $display("FAIL tx_pop_valid: got %b want 0", pop_if.ts_valid); end
      checks++; if (act !== exp) begin failures++; $display("FAIL tx_hold_last: got %h want %h", act, exp); end
      checks++; if (level !== 4'd0) begin failures++; $display("FAIL tx_pop_level: got %0d want 0", level); end
   endtask

   task automatic test_rx_paths();
      ts_entry_t act, exp;
      do_reset();
      ftm_time = 48'd2000; seq = 12'd7; rx_ev = 1; cycle();
      ftm_time = 48'd2050; bad = 1; cycle(); cycle();
      checks++; if (pop_if.ts_valid !== 1'b0) begin failures++; $display("FAIL rx_bad_valid: got %b want 0", pop_if.ts_valid); end
      ftm_time = 48'd3000; seq = 12'd8; rx_ev = 1; cycle();
      checks++; if (pop_if.ts_valid !== 1'b0) begin failures++; $display("FAIL rx_pend_valid: got %b want 0", pop_if.ts_valid); end
      ftm_time = 48'd3050; ok = 1; cycle();
      exp = '{48'd3000, 1'b0, 12'd8, 1'b0};
      act = head();
      checks++; if (act !== exp || pop_if.ts_valid !== 1'b1) begin failures++; $display("FAIL rx_ok_head: got %h v=%b want %h v=1", act, pop_if.ts_valid, exp); end
      ok = 1; cycle();
      ftm_time = 48'd3100; seq = 12'd9; rx_ev = 1; cycle();
      ok = 1; bad = 1; cycle();
      checks++; if (level !== 4'd1) begin failures++; $display("FAIL rx_idle_and_both: got level %0d want 1", level); end
      ftm_time = 48'd3200; seq = 12'd10; rx_ev = 1; cycle();
      ftm_time = 48'd3300; seq = 12'd11; rx_ev = 1; cycle();
      ok = 1; cycle();
      checks++; if (drop_cnt !== 16'd1 || level !== 4'd2) begin failures++; $display("FAIL rx_overwrite: got drop %0d level %0d want 1 2", drop_cnt, level); end
      ready = 1; cycle(); ready = 0;
      exp = '{48'd3300, 1'b0, 12'd11, 1'b0};
      act = head();
      checks++; if (act !== exp) begin failures++; $display("FAIL rx_overwrite_head: got %h want %h", act, exp); end
   endtask

   task automatic test_collision();
      ts_entry_t act;
      ts_entry_t exp[3];
      exp[0] = '{48'd4000, 1'b1, 12'd2, 1'b0};
      exp[1] = '{48'd5000, 1'b1, 12'd3, 1'b0};
      exp[2] = '{48'd3500, 1'b0, 12'd1, 1'b0};
      do_reset();
      ftm_time = 48'd3500; seq = 12'd1; rx_ev = 1; cycle();
      ftm_time = 48'd4000; seq = 12'd2; tx_ev = 1; cycle();
      ftm_time = 48'd5000; seq = 12'd3; tx_ev = 1; ok = 1; cycle();
      checks++; if (level !== 4'd2) begin failures++; $display("FAIL coll_hold_level: got %0d want 2", level); end
      cycle();
      checks++; if (level !== 4'd3) begin failures++; $display("FAIL coll_level: got %0d want 3", level); end
      for (int i = 0; i < 3; i++) begin
         act = head();
         checks++; if (act !== exp[i]) begin failures++; $display("FAIL coll_order%0d: got %h want %h", i, act, exp[i]); end
         ready = 1; cycle(); ready = 0;
      end
   endtask

   task automatic test_wrap();
      ts_entry_t act, exp;
      do_reset();
      ftm_time = 48'd0 - 48'd4000; cycle();
      ftm_time = 48'd0; cycle();
      ftm_time = 48'd100; seq = 12'd20; tx_ev = 1; cycle();
      ftm_time = 48'd200; seq = 12'd21; tx_ev = 1; cycle();
      exp = '{48'd100, 1'b1, 12'd20, 1'b1};
      act = head();
      checks++; if (act !== exp) begin failures++; $display("FAIL wrap_first: got %h want %h", act, exp); end
      ready = 1; cycle(); ready = 0;
      exp = '{48'd200, 1'b1, 12'd21, 1'b0};
      act = head();
      checks++; if (act !== exp) begin failures++; $display("FAIL wrap_second: got %h want %h", act, exp); end
      ftm_time = 48'd0 - 48'd10; cycle();
      ftm_time = 48'd5; seq = 12'd22; tx_ev = 1; cycle();
      ready = 1; cycle(); ready = 0;
      exp = '{48'd5, 1'b1, 12'd22, 1'b1};
      act = head();
      checks++; if (act !== exp) begin failures++; $display("FAIL wrap_same_cycle: got %h want %h", act, exp); end
   endtask

   task automatic test_overflow();
      ts_entry_t act, exp;
      do_reset();
      for (int i = 0; i < 10; i++) begin
         ftm_time = 48'(10000 + i * 10); seq = 12'(i); tx_ev = 1; cycle();
      end
      exp = '{48'd10000, 1'b1, 12'd0, 1'b0};
      act = head();
      checks++; if (level !== 4'd8) begin failures++; $display("FAIL ovf_level: got %0d want 8", level); end
      checks++; if (drop_cnt !== 16'd2) begin failures++; $display("FAIL ovf_drop: got %0d want 2", drop_cnt); end
      checks++; if (act !== exp) begin failures++; $display("FAIL ovf_head: got %h want %h", act, exp); end
      ftm_time = 48'd20000; seq = 12'd100; tx_ev = 1; ready = 1; cycle(); ready = 0;
      exp = '{48'd10010, 1'b1, 12'd1, 1'b0};
      act = head();
      checks++; if (level !== 4'd8 || drop_cnt !== 16'd2) begin failures++; $display("FAIL ovf_pop_push: got level %0d drop %0d want 8 2", level, drop_cnt); end
      checks++; if (act !== exp) begin failures++; $display("FAIL ovf_pop_head: got %h want %h", act, exp); end
   endtask

   task automatic test_reset_in_pend();
      do_reset();
      ftm_time = 48'd6000; seq = 12'd30; rx_ev = 1; cycle();
      ftm_time = 48'd6100; seq = 12'd31; rx_ev = 1; cycle();
      checks++; if (drop_cnt !== 16'd1) begin failures++; $display("FAIL rst_pend_pre_drop: got %0d want 1", drop_cnt); end
      rstn = 0; cycle(); rstn = 1;
      ok = 1; cycle(); cycle();
      checks++; if (pop_if.ts_valid !== 1'b0 || level !== 4'd0 || drop_cnt !== 16'd0) begin failures++; $display("FAIL rst_pend: got v=%b level %0d drop %0d want 0 0 0", pop_if.ts_valid, level, drop_cnt); end
      ftm_time = 48'd6200; seq = 12'd32; rx_ev = 1; cycle();
      ftm_time = 48'd6300; seq = 12'd33; tx_ev = 1; ok = 1; cycle();
      rstn = 0; cycle(); rstn = 1; cycle();
      checks++; if (level !== 4'd0 || drop_cnt !== 16'd0) begin failures++; $display("FAIL rst_hold: got level %0d drop %0d want 0 0", level, drop_cnt); end
   endtask

   task automatic test_random();
      ts_entry_t act, exp;
      int ready_pct;
      do_reset();
      ready_pct = 50;
      for (int n = 0; n < 4000; n++) begin
         if (n % 500 == 0) ready_pct = (n / 500 % 3 == 0) ? 10 : ((n / 500 % 3 == 1) ? 90 : 50);
         if ($urandom_range(0, 199) == 0) ftm_time = 48'd0 - 48'($urandom_range(1, 300));
         else ftm_time = ftm_time + 48'($urandom_range(0, 50));
         tx_ev = ($urandom_range(0, 4) == 0);
         rx_ev = ($urandom_range(0, 3) == 0);
         ok    = ($urandom_range(0, 3) == 0);
         bad   = ($urandom_range(0, 5) == 0);
         seq   = 12'($urandom);
         ready = ($urandom_range(0, 99) < ready_pct);
         cycle();
         exp = (mq.size() > 0) ? mq[0] : m_last;
         act = head();
         checks++; if (pop_if.ts_valid !== (mq.size() > 0)) begin failures++; $display("FAIL rnd_valid@%0d: got %b want %b", n, pop_if.ts_valid, mq.size() > 0); end
         checks++; if (act !== exp) begin failures++; $display("FAIL rnd_head@%0d: got %h want %h", n, act, exp); end
         checks++; if (level !== 4'(mq.size())) begin failures++; $display("FAIL rnd_level@%0d: got %0d want %0d", n, level, mq.size()); end
         checks++; if (drop_cnt !== 16'((m_drops > 65535) ? 65535 : m_drops)) begin failures++; $display("FAIL rnd_drop@%0d: got %0d want %0d", n, drop_cnt, m_drops); end
      end
      ready = 0;
   endtask

   initial begin
      test_reset();
      test_single_tx();
      test_rx_paths();
      test_collision();
      test_wrap();
      test_overflow();
      test_reset_in_pend();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
